// File: rtl/uart_fifo_ram.sv
// rtl/uart_fifo_ram.sv - simple dual-port byte array, synchronous write, asynchronous read
module uart_fifo_ram #(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      r_mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive byte FIFO with FWFT valid/ready output and sticky overrun flag
module uart_rx_fifo #(
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [7:0]             rx_data_i,
  input  logic                   rx_done_i,
  output logic [7:0]             data_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   almost_full_o,
  output logic                   overflow_o,
  input  logic                   clear_ovf_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_valid;
  logic             r_full;
  logic             r_af;
  logic             r_ovf;
  logic [7:0]       r_hold;

  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [7:0]       w_rd_data;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a byte then.
  assign w_pop  = r_valid & ready_i;
  assign w_push = rx_done_i & (~r_full | w_pop);
  assign w_drop = rx_done_i & r_full & ~w_pop;

  always_comb begin
    w_cnt_nxt = r_count;
    if (w_push && !w_pop) begin
      w_cnt_nxt = r_count + CNT_W'(1);
    end else if (w_pop && !w_push) begin
      w_cnt_nxt = r_count - CNT_W'(1);
    end
  end

  uart_fifo_ram #(
    .DEPTH  (DEPTH),
    .WIDTH  (8),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (w_push),
    .waddr_i (r_wr_ptr),
    .wdata_i (rx_data_i),
    .raddr_i (r_rd_ptr),
    .rdata_o (w_rd_data)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_full   <= 1'b0;
      r_af     <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= w_cnt_nxt;
      r_valid <= (w_cnt_nxt != '0);
      r_full  <= (w_cnt_nxt == CNT_W'(DEPTH));
      r_af    <= (w_cnt_nxt >= CNT_W'(AF_LEVEL));
    end
  end

  // Drop wins over clear so an overrun in the clearing cycle is never lost.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (clear_ovf_i) begin
      r_ovf <= 1'b0;
    end
  end

  // Storage is not reset; the hold register keeps data_o defined while empty.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hold <= 8'h00;
    end else if (r_valid) begin
      r_hold <= w_rd_data;
    end
  end

  assign data_o        = r_valid ? w_rd_data : r_hold;
  assign valid_o       = r_valid;
  assign count_o       = r_count;
  assign full_o        = r_full;
  assign almost_full_o = r_af;
  assign overflow_o    = r_ovf;

endmodule
